// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single D-MEM port between the pipeline MEM stage and a loader master.
// Optional DMEM_ARB_STATS_EN adds stall_cnt_o / grant_cnt_o statistics outputs.
module dmem_port_arbiter #(
    parameter int DBITS    = 32,
    parameter int MAX_WAIT = 4,
    parameter int WAITBITS = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             pipe_valid_i,
    input  logic             pipe_we_i,
    input  logic [DBITS-1:0] pipe_addr_i,
    input  logic [DBITS-1:0] pipe_wdata_i,
    output logic [DBITS-1:0] pipe_rdata_o,
    output logic             pipe_stall_o,
    input  logic             ld_req_i,
    input  logic             ld_we_i,
    input  logic [DBITS-1:0] ld_addr_i,
    input  logic [DBITS-1:0] ld_wdata_i,
    output logic             ld_ack_o,
    output logic [DBITS-1:0] ld_rdata_o,
    output logic [DBITS-1:0] mem_addr_o,
    output logic             mem_we_o,
    output logic [DBITS-1:0] mem_wdata_o,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]      stall_cnt_o,
    output logic [31:0]      grant_cnt_o,
`endif
    input  logic [DBITS-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LD_ACC = 2'd1,
        LD_ACK = 2'd2
    } state_t;

    localparam logic [WAITBITS-1:0] MAX_W = WAITBITS'(MAX_WAIT);

    state_t              state_q, state_d;
    logic [WAITBITS-1:0] wait_cnt_q, wait_cnt_d;
    logic                ld_ack_q, ld_ack_d;
    logic [DBITS-1:0]    ld_rdata_q, ld_rdata_d;
    logic                sel_ld;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            ld_ack_q   <= 1'b0;
            ld_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ld_ack_q   <= ld_ack_d;
            ld_rdata_q <= ld_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ld_ack_d   = 1'b0;
        ld_rdata_d = ld_rdata_q;
        case (state_q)
            IDLE: begin
                if (!ld_req_i) begin
                    wait_cnt_d = '0;
                end else if (pipe_valid_i && (wait_cnt_q != MAX_W)) begin
                    wait_cnt_d = wait_cnt_q + WAITBITS'(1);
                end
                if (ld_req_i && (!pipe_valid_i || (wait_cnt_q == MAX_W))) begin
                    state_d = LD_ACC;
                end
            end
            LD_ACC: begin
                // The loader access completes at this edge; the ack covers the following cycle.
                ld_rdata_d = mem_rdata_i;
                ld_ack_d   = 1'b1;
                wait_cnt_d = '0;
                state_d    = LD_ACK;
            end
            LD_ACK: begin
                wait_cnt_d = '0;
                state_d    = IDLE;
            end
            default: begin
                wait_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    always_comb begin
        sel_ld       = (state_q == LD_ACC);
        mem_addr_o   = sel_ld ? ld_addr_i  : pipe_addr_i;
        mem_wdata_o  = sel_ld ? ld_wdata_i : pipe_wdata_i;
        mem_we_o     = sel_ld ? ld_we_i    : (pipe_valid_i & pipe_we_i);
        pipe_stall_o = sel_ld & pipe_valid_i;
        pipe_rdata_o = mem_rdata_i;
        ld_ack_o     = ld_ack_q;
        ld_rdata_o   = ld_rdata_q;
    end

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] grant_cnt_q, grant_cnt_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
            grant_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q + (pipe_stall_o ? 32'd1 : 32'd0);
        grant_cnt_d = grant_cnt_q +
                      (((state_q == IDLE) && (state_d == LD_ACC)) ? 32'd1 : 32'd0);
    end

    assign stall_cnt_o = stall_cnt_q;
    assign grant_cnt_o = grant_cnt_q;
`endif

endmodule
